fios_result_collector: RTL and testbench

Receives the stream of 34-bit products-plus-accumulate values leaving a Processing Element's DSP slice and turns them into normalised 17-bit result words. It propagates the carry between consecutive words and buffers the words in a small FIFO with a valid/ready output handshake. It sits between a PE's DSP output and the result bus of the FIOS Montgomery multiplier. The DSP pipeline cannot stall, so the collector accepts input unconditionally and flags overflow.

---
 rtl/fios_result_collector_if.sv | 44 ++++
 rtl/fios_result_collector.sv | 190 +++++++++++++++++++
 tb/tb_fios_result_collector.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fios_result_collector_if.sv
// -----------------------------------------------------------------------------
// fios_result_collector_if
//   Groups the DSP-side input stream and the result-bus output handshake of
//   fios_result_collector.
//
//   Signals:
//     P_valid_i    DSP output valid (no backpressure, the DSP cannot stall)
//     P_i[33:0]    DSP output value P
//     res_o[16:0]  head-of-FIFO result word
//     res_valid_o  FIFO not empty
//     res_ready_i  consumer accepts res_o
//
//   Handshake: a result word transfers on every rising clock edge where
//   res_valid_o && res_ready_i. res_o/res_valid_o depend only on registers,
//   and res_valid_o does not wait for res_ready_i. P_valid_i has no ready:
//   every asserted cycle is taken (or dropped with overflow flagged).
//
//   Modports:
//     slave  : the collector (consumes P, produces res)
//     master : the environment (produces P, consumes res)
// -----------------------------------------------------------------------------
interface fios_result_collector_if;
  logic        P_valid_i;
  logic [33:0] P_i;
  logic [16:0] res_o;
  logic        res_valid_o;
  logic        res_ready_i;

  modport slave (
    input  P_valid_i,
    input  P_i,
    input  res_ready_i,
    output res_o,
    output res_valid_o
  );

  modport master (
    output P_valid_i,
    output P_i,
    output res_ready_i,
    input  res_o,
    input  res_valid_o
  );
endinterface

// File: rtl/fios_result_collector.sv
// -----------------------------------------------------------------------------
// fios_result_collector
//   Turns the 34-bit DSP output stream of a FIOS Processing Element into
//   normalised 17-bit words, propagating an 18-bit carry from word to word,
//   and buffers the words in a small FIFO towards the result bus.
//
//   Ports:
//     clock_i      rising-edge clock
//     reset_i      asynchronous active-high reset
//     start_i      one-cycle pulse: (re)arm a collection, clear FIFO/carry/overflow
//     bus          fios_result_collector_if.slave (P stream in, result words out)
//     busy_o       state != IDLE
//     done_o       one-cycle pulse after the last word of a collection is popped
//     overflow_o   sticky: a word was dropped because the FIFO was full
//     dbg_state_o  current FSM state (0 IDLE, 1 COLLECT, 2 FLUSH, 3 DRAIN)
//
//   Configuration macro: FIOS_COLLECTOR_FINAL_CARRY_EN
//     defined     : FLUSH state pushes the final carry as word WORD_COUNT
//     not defined : WORD_COUNT words only, residual carry discarded
// -----------------------------------------------------------------------------
module fios_result_collector #(
  parameter int WORD_COUNT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  fios_result_collector_if.slave        bus,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          overflow_o,
  output logic [1:0]                    dbg_state_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(WORD_COUNT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FLUSH   = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t          r_state, w_state_next;

  logic [16:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [AW:0]     r_count;
  logic [17:0]     r_carry, w_carry_next, w_carry_base;
  logic [CW-1:0]   r_word_cnt, w_word_cnt_next;
  logic            r_overflow, r_done;

  logic            w_push, w_push_ok, w_pop, w_clear, w_done_next;
  logic            w_full, w_empty;
  logic [16:0]     w_push_data;
  logic [34:0]     w_sum;

  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // start_i flushes the FIFO, so nothing is popped in that cycle.
  assign w_pop = !w_empty && bus.res_ready_i && !start_i;

  // A word coincident with start_i is word 0 of the new collection: carry 0.
  assign w_carry_base = start_i ? 18'd0 : r_carry;
  assign w_sum        = {1'b0, bus.P_i} + {17'd0, w_carry_base};

  // A push into a full FIFO only succeeds if a pop frees the head this cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_push          = 1'b0;
    w_push_data     = w_sum[16:0];
    w_carry_next    = r_carry;
    w_word_cnt_next = r_word_cnt;
    w_clear         = 1'b0;
    w_done_next     = 1'b0;

    if (start_i) begin
      w_clear         = 1'b1;
      w_state_next    = S_COLLECT;
      w_carry_next    = 18'd0;
      w_word_cnt_next = '0;
      if (bus.P_valid_i) begin
        // WORD_COUNT >= 2, so one word never completes a collection.
        w_push          = 1'b1;
        w_carry_next    = w_sum[34:17];
        w_word_cnt_next = CW'(1);
      end
    end else begin
      case (r_state)
        S_IDLE: begin
        end
        S_COLLECT: begin
          if (bus.P_valid_i) begin
            w_push          = 1'b1;
            w_carry_next    = w_sum[34:17];
            w_word_cnt_next = r_word_cnt + CW'(1);
            if (r_word_cnt == CW'(WORD_COUNT - 1)) begin
`ifdef FIOS_COLLECTOR_FINAL_CARRY_EN
              w_state_next = S_FLUSH;
`else
              w_state_next = S_DRAIN;
              w_carry_next = 18'd0;
`endif
            end
          end
        end
`ifdef FIOS_COLLECTOR_FINAL_CARRY_EN
        S_FLUSH: begin
          // carry[17] cannot be represented in the extra word and is dropped.
          w_push       = 1'b1;
          w_push_data  = r_carry[16:0];
          w_carry_next = 18'd0;
          w_state_next = S_DRAIN;
        end
`endif
        S_DRAIN: begin
          if (w_empty || (w_pop && r_count == (AW+1)'(1))) begin
            w_done_next  = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Carry, word counter, FIFO and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_carry    <= 18'd0;
      r_word_cnt <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 17'd0;
    end else begin
      r_carry    <= w_carry_next;
      r_word_cnt <= w_word_cnt_next;
      r_done     <= w_done_next;
      if (w_clear) begin
        r_rd_ptr   <= '0;
        r_overflow <= 1'b0;
        if (w_push) begin
          r_mem[0] <= w_push_data;
          r_wr_ptr <= AW'(1);
          r_count  <= (AW+1)'(1);
        end else begin
          r_wr_ptr <= '0;
          r_count  <= '0;
        end
      end else begin
        if (w_push_ok) begin
          r_mem[r_wr_ptr] <= w_push_data;
          r_wr_ptr        <= r_wr_ptr + AW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push_ok && !w_pop)      r_count <= r_count + (AW+1)'(1);
        else if (w_pop && !w_push_ok) r_count <= r_count - (AW+1)'(1);
        if (w_push && !w_push_ok) r_overflow <= 1'b1;
      end
    end
  end

  assign bus.res_o       = r_mem[r_rd_ptr];
  assign bus.res_valid_o = !w_empty;
  assign busy_o          = (r_state != S_IDLE);
  assign done_o          = r_done;
  assign overflow_o      = r_overflow;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_fios_result_collector.sv
// -----------------------------------------------------------------------------
// tb_fios_result_collector
//   Bench for fios_result_collector with WORD_COUNT=6, FIFO_DEPTH=4. Expected
//   result words are queued as stimulus is driven and compared as the DUT
//   hands them over on the result bus.
// -----------------------------------------------------------------------------
module tb_fios_result_collector;

  localparam int WC = 6;
  localparam int FD = 4;
`ifdef FIOS_COLLECTOR_FINAL_CARRY_EN
  localparam int FINAL = 1;
`else
  localparam int FINAL = 0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clock_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       start_i = 1'b0;
  logic       busy_o, done_o, overflow_o;
  logic [1:0] dbg_state_o;

  fios_result_collector_if bus();

  fios_result_collector #(.WORD_COUNT(WC), .FIFO_DEPTH(FD)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .bus         (bus),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .overflow_o  (overflow_o),
    .dbg_state_o (dbg_state_o)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [16:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int first_pop, last_pop, pop_cnt, done_cnt, done_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clock_i) begin
    if (!reset_i) begin
      if (bus.res_valid_o && bus.res_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got 0x%0h, no word expected (cycle %0d)", bus.res_o, cyc);
        end else begin
          check("word", 64'(bus.res_o), 64'(exp_q.pop_front()));
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        pop_cnt++;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic st, input logic pv, input logic [33:0] p);
    start_i       = st;
    bus.P_valid_i = pv;
    bus.P_i       = p;
    @(posedge clock_i);
    #1;
    start_i       = 1'b0;
    bus.P_valid_i = 1'b0;
  endtask

  task automatic send(input logic [33:0] p, input logic [16:0] w);
    exp_q.push_back(w);
    drive(1'b0, 1'b1, p);
  endtask

  task automatic clear_stats();
    first_pop = -1;
    last_pop  = -1;
    pop_cnt   = 0;
    done_cnt  = 0;
    done_cyc  = -1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 80) begin
      @(posedge clock_i);
      #1;
      n++;
    end
    check({name, "_drained"}, 64'(n < 80), 64'(1));
    exp_q.delete();
    repeat (2) begin
      @(posedge clock_i);
      #1;
    end
    check({name, "_done_count"}, 64'(done_cnt), 64'(1));
    check({name, "_done_timing"}, 64'(done_cyc), 64'(last_pop + 1));
    check({name, "_idle"}, 64'(dbg_state_o), 64'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: two full collections, {P, expected word}
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [33:0] p;
    logic [16:0] w;
  } vec_t;

  vec_t        tbl[2*WC];
  logic [16:0] flush_w[2];

  initial begin
    int p0_cyc;

    tbl[0]  = '{34'h3_FFFF_FFFF, 17'h1FFFF};
    tbl[1]  = '{34'h0_0000_0001, 17'h00000};
    tbl[2]  = '{34'h0_0001_FFFF, 17'h00000};
    tbl[3]  = '{34'h0_0000_0000, 17'h00001};
    tbl[4]  = '{34'h0_0000_0000, 17'h00000};
    tbl[5]  = '{34'h0_0000_0000, 17'h00000};
    flush_w[0] = 17'h00000;
    tbl[6]  = '{34'h0_0001_2345, 17'h12345};
    tbl[7]  = '{34'h1_2345_6789, 17'h16789};
    tbl[8]  = '{34'h0_0000_FFFF, 17'h191A1};
    tbl[9]  = '{34'h3_FFFE_0000, 17'h00000};
    tbl[10] = '{34'h0_0000_0001, 17'h00000};
    tbl[11] = '{34'h2_0000_0000, 17'h00001};
    flush_w[1] = 17'h10000;

    bus.P_valid_i   = 1'b0;
    bus.P_i         = '0;
    bus.res_ready_i = 1'b0;
    clear_stats();

    // ---- reset state ----
    #2 reset_i = 1'b1;
    #1;
    check("rst_res_o", 64'(bus.res_o), 64'(0));
    check("rst_res_valid", 64'(bus.res_valid_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_overflow", 64'(overflow_o), 64'(0));
    check("rst_state", 64'(dbg_state_o), 64'(0));
    @(posedge clock_i);
    #1 reset_i = 1'b0;
    @(posedge clock_i);
    #1;

    // ---- carry chain, ready held high, two collections ----
    bus.res_ready_i = 1'b1;
    for (int s = 0; s < 2; s++) begin
      clear_stats();
      drive(1'b1, 1'b0, '0);
      p0_cyc = cyc;
      for (int i = 0; i < WC; i++) send(tbl[s*WC + i].p, tbl[s*WC + i].w);
      if (FINAL != 0) exp_q.push_back(flush_w[s]);
      wait_drain("chain");
      check("chain_latency", 64'(first_pop), 64'(p0_cyc + 1));
      check("chain_back_to_back", 64'(last_pop - first_pop), 64'(WC + FINAL - 1));
      check("chain_pop_count", 64'(pop_cnt), 64'(WC + FINAL));
    end

    // ---- backpressure and overflow ----
    clear_stats();
    bus.res_ready_i = 1'b0;
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < WC; i++) begin
      if (i < FD) exp_q.push_back(17'h5);
      drive(1'b0, 1'b1, 34'h5);
      if (i == 0) check("bp_valid_first", 64'(bus.res_valid_o), 64'(1));
      if (i == FD - 1) check("bp_no_overflow_full", 64'(overflow_o), 64'(0));
      if (i == FD) check("bp_overflow_set", 64'(overflow_o), 64'(1));
    end
    bus.res_ready_i = 1'b1;
    if (FINAL != 0) exp_q.push_back(17'h0);
    wait_drain("bp");
    check("bp_overflow_sticky", 64'(overflow_o), 64'(1));
    check("bp_pop_count", 64'(pop_cnt), 64'(FD + FINAL));

    // ---- full FIFO with simultaneous push and pop ----
    clear_stats();
    bus.res_ready_i = 1'b0;
    drive(1'b1, 1'b0, '0);
    for (int i = 1; i <= FD; i++) send(34'(i), 17'(i));
    check("fullpop_cleared", 64'(overflow_o), 64'(0));
    bus.res_ready_i = 1'b1;
    send(34'h5, 17'h5);
    bus.res_ready_i = 1'b0;
    check("fullpop_overflow_a", 64'(overflow_o), 64'(0));
    check("fullpop_valid", 64'(bus.res_valid_o), 64'(1));
    bus.res_ready_i = 1'b1;
    send(34'h6, 17'h6);
    check("fullpop_overflow_b", 64'(overflow_o), 64'(0));
    if (FINAL != 0) exp_q.push_back(17'h0);
    wait_drain("fullpop");
    check("fullpop_overflow_end", 64'(overflow_o), 64'(0));
    check("fullpop_pop_count", 64'(pop_cnt), 64'(WC + FINAL));

    // ---- restart mid-collection after overflow, carry nonzero ----
    clear_stats();
    bus.res_ready_i = 1'b0;
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < FD + 1; i++) drive(1'b0, 1'b1, 34'h3_FFFF_FFFF);
    check("restart_pre_overflow", 64'(overflow_o), 64'(1));
    drive(1'b1, 1'b0, '0);
    check("restart_fifo_empty", 64'(bus.res_valid_o), 64'(0));
    check("restart_overflow_clr", 64'(overflow_o), 64'(0));
    check("restart_state", 64'(dbg_state_o), 64'(1));
    bus.res_ready_i = 1'b1;
    send(34'h7, 17'h7);
    for (int i = 1; i < WC; i++) send(34'h0, 17'h0);
    if (FINAL != 0) exp_q.push_back(17'h0);
    wait_drain("restart");

    // ---- restart with a coincident word ----
    clear_stats();
    bus.res_ready_i = 1'b0;
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 34'h3_FFFF_FFFF);
    exp_q.push_back(17'h9);
    drive(1'b1, 1'b1, 34'h0_0002_0009);
    check("restart_coincident_valid", 64'(bus.res_valid_o), 64'(1));
    bus.res_ready_i = 1'b1;
    send(34'h0, 17'h1);
    for (int i = 2; i < WC; i++) send(34'h0, 17'h0);
    if (FINAL != 0) exp_q.push_back(17'h0);
    wait_drain("coincident");
    check("coincident_pop_count", 64'(pop_cnt), 64'(WC + FINAL));

    // ---- asynchronous reset mid-collection ----
    clear_stats();
    bus.res_ready_i = 1'b0;
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 34'h3);
    drive(1'b0, 1'b1, 34'h4);
    check("areset_pre_valid", 64'(bus.res_valid_o), 64'(1));
    #2 reset_i = 1'b1;
    #1;
    check("areset_res_o", 64'(bus.res_o), 64'(0));
    check("areset_valid", 64'(bus.res_valid_o), 64'(0));
    check("areset_busy", 64'(busy_o), 64'(0));
    check("areset_state", 64'(dbg_state_o), 64'(0));
    #2 reset_i = 1'b0;
    @(posedge clock_i);
    #1;
    bus.res_ready_i = 1'b1;
    drive(1'b0, 1'b1, 34'h11);
    drive(1'b0, 1'b0, '0);
    check("areset_pvalid_ignored", 64'(bus.res_valid_o), 64'(0));
    check("areset_still_idle", 64'(busy_o), 64'(0));
    check("areset_no_pops", 64'(pop_cnt), 64'(0));

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
